// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared word width and the NOOP/HALT encodings used by the fetch path.
// Rev 1.0
`default_nettype none

package fetch_unit_pkg;

  localparam int ARCH_SIZE = 15;

  typedef logic [ARCH_SIZE:0] word_t;

  localparam word_t NOOP = 16'h1000;
  localparam word_t HALT = 16'hF000;

  function automatic logic is_halt(input word_t w);
    return (w == HALT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_timeout.sv
// fetch_timeout: per-handshake-phase wait counter with an expiry flag.
// Rev 1.0
`default_nettype none

module fetch_timeout #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Flags the edge on which the count would reach TIMEOUT, so the owner can
  // leave the waiting state on that same edge.
  assign expired_o = enable_i && (count_q == (TIMEOUT - 8'd1));

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = 8'd0;
    end else if (enable_i) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch initiator on a four-phase mem_read/mem_ready handshake.
// Rev 1.0
`default_nettype none

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter word_t      RESET_PC = '0,
  parameter logic [7:0] TIMEOUT  = 8'd255
) (
  input  logic  clock,
  input  logic  reset_n,
  input  logic  start,
  output word_t mem_address,
  output logic  mem_read,
  input  word_t mem_value,
  input  logic  mem_ready,
  output word_t instr,
  output logic  instr_valid,
  input  logic  instr_accept,
  output logic  halted,
  output logic  error
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_RELEASE = 3'd2,
    ST_PRESENT = 3'd3,
    ST_HALTED  = 3'd4,
    ST_ERROR   = 3'd5
  } state_e;

  state_e state_q, state_d;
  word_t  pc_q, pc_d;
  word_t  instr_q, instr_d;
  logic   mem_read_q;
  logic   instr_valid_q;
  logic   halted_q;
  logic   error_q;

  logic   wait_clear;
  logic   wait_enable;
  logic   wait_expired;

  assign wait_enable = (state_q == ST_REQ) || (state_q == ST_RELEASE);
  assign wait_clear  = (state_d != state_q);

  fetch_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear_i   (wait_clear),
    .enable_i  (wait_enable),
    .expired_o (wait_expired)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (mem_ready) begin
          instr_d = mem_value;
          state_d = ST_RELEASE;
        end else if (wait_expired) begin
          state_d = ST_ERROR;
        end
      end
      ST_RELEASE: begin
        if (!mem_ready) begin
          state_d = ST_PRESENT;
        end else if (wait_expired) begin
          state_d = ST_ERROR;
        end
      end
      ST_PRESENT: begin
        if (instr_accept) begin
          if (is_halt(instr_q)) begin
            state_d = ST_HALTED;
          end else begin
            pc_d    = pc_q + word_t'(1);
            state_d = ST_REQ;
          end
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      ST_ERROR:  state_d = ST_ERROR;
      default:   state_d = ST_ERROR;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet
  // aligned with the state they describe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      mem_read_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      mem_read_q    <= (state_d == ST_REQ);
      instr_valid_q <= (state_d == ST_PRESENT);
      halted_q      <= (state_d == ST_HALTED);
      error_q       <= (state_d == ST_ERROR);
    end
  end

  assign mem_address = pc_q;
  assign mem_read    = mem_read_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;
  assign error       = error_q;

endmodule

`default_nettype wire
